// File: rtl/mips_input_conditioner.sv
// mips_input_conditioner: synchronizes and debounces board switches/buttons
// into single-cycle load and port-reset strobes for mips_top.
module mips_input_conditioner #(
    parameter int SW_WIDTH  = 10,
    parameter int DB_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw,
    input  logic                sel_sw,
    input  logic                btn_load,
    input  logic                btn_rst,
    output logic [31:0]         user_input,
    output logic                port_sel,
    output logic                port_en,
    output logic                port_rst
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    // Button index: 0 = load, 1 = port reset.
    localparam int B_LOAD = 0;
    localparam int B_RST  = 1;

    logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
    logic                sel_s1_q, sel_s2_q;
    logic [1:0]          btn_s1_q, btn_s2_q;

    logic [1:0]          stab_q, stab_d;
    logic [1:0]          stab_dly_q;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;
    logic [1:0]          rise;

    logic [31:0]         ui_q, ui_d;
    logic                sel_q, sel_d;
    logic                en_q, en_d;
    logic                prst_q, prst_d;

    // Two-flop synchronizers for every asynchronous board input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            sel_s1_q <= 1'b0;
            sel_s2_q <= 1'b0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            sel_s1_q <= sel_sw;
            sel_s2_q <= sel_s1_q;
            btn_s1_q <= {btn_rst, btn_load};
            btn_s2_q <= btn_s1_q;
        end
    end

    // Debouncer next state: a level is accepted only after DB_CYCLES
    // consecutive differing samples; any return to stable restarts.
    always_comb begin
        stab_d = stab_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (btn_s2_q[i] == stab_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stab_d[i] = btn_s2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Debouncer state and the delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            stab_q     <= '0;
            stab_dly_q <= '0;
            cnt_q      <= '0;
        end else begin
            stab_q     <= stab_d;
            stab_dly_q <= stab_q;
            cnt_q      <= cnt_d;
        end
    end

    assign rise = stab_q & ~stab_dly_q;

    // Output next state: port reset takes priority over a load.
    always_comb begin
        ui_d   = ui_q;
        sel_d  = sel_q;
        en_d   = 1'b0;
        prst_d = 1'b0;
        if (rise[B_RST]) begin
            prst_d = 1'b1;
            ui_d   = '0;
            sel_d  = 1'b0;
        end else if (rise[B_LOAD]) begin
            en_d                 = 1'b1;
            ui_d                 = '0;
            ui_d[SW_WIDTH-1:0]   = sw_s2_q;
            sel_d                = sel_s2_q;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ui_q   <= '0;
            sel_q  <= 1'b0;
            en_q   <= 1'b0;
            prst_q <= 1'b0;
        end else begin
            ui_q   <= ui_d;
            sel_q  <= sel_d;
            en_q   <= en_d;
            prst_q <= prst_d;
        end
    end

    assign user_input = ui_q;
    assign port_sel   = sel_q;
    assign port_en    = en_q;
    assign port_rst   = prst_q;

endmodule
